// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the bitwise logic unit and its arbiter.
package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT     = 3'd0;
  localparam logic [OP_W-1:0] OP_OR      = 3'd1;
  localparam logic [OP_W-1:0] OP_AND     = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR     = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR     = 3'd4;
  localparam logic [OP_W-1:0] OP_NAND    = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR    = 3'd6;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd7;

endpackage

// File: rtl/logic_unit.sv
// Purely combinational two-operand bitwise datapath; illegal opcodes yield zero with err set.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  // Opcode decode; b is unused for NOT
  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_NOT:  y = ~a;
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_NAND: y = ~(a & b);
      OP_XNOR: y = ~(a ^ b);
      default: begin
        y   = '0;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit among NREQ requesters,
// returning each result through a single registered, ID-tagged response port.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [OP_W*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0]    req_a,
  input  logic [WIDTH*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  input  logic                     rsp_ready
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   winner;
  logic             found;
  logic             accept;
  logic             grant;
  int               idx;
  logic [OP_W-1:0]  sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] lu_y;
  logic             lu_err;
  logic [IDW-1:0]   ptr_next;

  assign accept = ~rsp_valid | rsp_ready;

  // Priority search starting at ptr, wrapping modulo NREQ (NREQ need not be a power of two)
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end else begin
        found  = found;
      end
    end
  end

  // Reset holds off grants so nothing transfers while rst is high
  assign grant = found & accept & ~rst;

  // One-hot grant to the winner
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Payload multiplexer feeding the single shared datapath
  always_comb begin
    sel_op = req_op[OP_W*int'(winner) +: OP_W];
    sel_a  = req_a[WIDTH*int'(winner) +: WIDTH];
    sel_b  = req_b[WIDTH*int'(winner) +: WIDTH];
  end

  logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
    .op  (sel_op),
    .a   (sel_a),
    .b   (sel_b),
    .y   (lu_y),
    .err (lu_err)
  );

  assign ptr_next = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;

  // Response register and round-robin pointer; a new grant overwrites a draining response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      ptr       <= '0;
    end else if (grant) begin
      rsp_valid <= 1'b1;
      rsp_id    <= winner;
      rsp_data  <= lu_y;
      rsp_err   <= lu_err;
      ptr       <= ptr_next;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: a reference arbiter model predicts grants and results.
module tb_logic_unit_arbiter;
  import logic_unit_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;
  logic                  rsp_ready;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
    logic             err;
  } rsp_t;

  rsp_t           sbq[$];
  logic [2:0]     op_v [NREQ];
  logic [7:0]     a_v  [NREQ];
  logic [7:0]     b_v  [NREQ];
  logic [IDW-1:0] m_ptr;
  logic           m_valid;
  logic [NREQ-1:0] samp_rdy;
  int             tests_run = 0;
  int             tests_failed = 0;
  int             id3_seen = 0;

  logic [7:0] sweep_tbl [8] = '{8'h3A, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
  logic [3:0] skip_tbl  [3] = '{4'b1000, 4'b0010, 4'b1000};

  logic_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic rsp_t ref_op(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    rsp_t r;
    r.id  = IDW'(id);
    r.err = 1'b0;
    case (op)
      3'd0:    r.data = ~a;
      3'd1:    r.data = a | b;
      3'd2:    r.data = a & b;
      3'd3:    r.data = a ^ b;
      3'd4:    r.data = ~(a | b);
      3'd5:    r.data = ~(a & b);
      3'd6:    r.data = ~(a ^ b);
      default: begin r.data = 8'h00; r.err = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_op[3*i +: 3] = op_v[i];
      req_a[8*i +: 8]  = a_v[i];
      req_b[8*i +: 8]  = b_v[i];
    end
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < NREQ; i++) begin
      op_v[i] = 3'($urandom_range(7, 0));
      a_v[i]  = 8'($urandom);
      b_v[i]  = 8'($urandom);
    end
  endtask

  // Called at a falling edge: predict grant, check it, advance model across one rising edge, check response
  task automatic step();
    logic [3:0] exp_rdy;
    logic       acc;
    int         w;
    int         idx;
    rsp_t       front;
    drive();
    #1;
    acc = !m_valid || rsp_ready;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(m_ptr) + k) % NREQ;
      if (w < 0 && req_valid[idx]) w = idx;
    end
    exp_rdy = (acc && w >= 0) ? (4'b0001 << w) : 4'b0000;
    samp_rdy = req_ready;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (m_valid && rsp_ready) begin
      front = sbq.pop_front();
      m_valid = 1'b0;
    end
    if (exp_rdy != 4'b0000) begin
      sbq.push_back(ref_op(w, op_v[w], a_v[w], b_v[w]));
      m_valid = 1'b1;
      m_ptr = (w == NREQ - 1) ? 2'd0 : IDW'(w + 1);
    end
    @(posedge clk);
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      if (sbq.size() == 0) begin
        check("sb_nonempty", 32'(0), 32'(1));
      end else begin
        front = sbq[0];
        check("rsp_id", 32'(rsp_id), 32'(front.id));
        check("rsp_data", 32'(rsp_data), 32'(front.data));
        check("rsp_err", 32'(rsp_err), 32'(front.err));
      end
      if (rsp_valid && rsp_id == 2'd3) id3_seen++;
    end
  endtask

  initial begin
    int n_xfer;
    logic got3;
    rst = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_v[i] = 3'd0; a_v[i] = 8'h00; b_v[i] = 8'h00;
    end
    drive();
    m_ptr = 2'd0;
    m_valid = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_id", 32'(rsp_id), 32'(0));
    check("rst_rsp_data", 32'(rsp_data), 32'(0));
    check("rst_rsp_err", 32'(rsp_err), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    step();
    step();

    // Opcode sweep on requester 2
    a_v[2] = 8'hC5;
    b_v[2] = 8'h3A;
    req_valid = 4'b0100;
    for (int op = 0; op < 8; op++) begin
      op_v[2] = 3'(op);
      step();
      check("sweep_data", 32'(rsp_data), 32'(sweep_tbl[op]));
      check("sweep_err", 32'(rsp_err), (op == 7) ? 32'(1) : 32'(0));
      check("sweep_id", 32'(rsp_id), 32'(2));
    end

    // Skip/wrap from ptr=3 with requesters 1 and 3 only
    randomize_payload();
    req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      check("skip_grant", 32'(samp_rdy), 32'(skip_tbl[i]));
    end
    req_valid = 4'b1111;
    step();
    check("ptr_wrap", 32'(samp_rdy), 32'(4'b0001));

    // Round-robin, all requesters valid
    for (int i = 0; i < 8; i++) begin
      randomize_payload();
      step();
      check("rr_grant", 32'(samp_rdy), 32'(4'b0001 << ((1 + i) % 4)));
      check("rr_onehot", 32'($onehot(samp_rdy)), 32'(1));
    end

    // Backpressure then drain-and-grant in one cycle
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_ready", 32'(samp_rdy), 32'(0));
    end
    rsp_ready = 1'b1;
    step();
    check("bp_drain", 32'(samp_rdy), 32'(4'b0010));

    // Fairness: requester 0 always valid, requester 3 asserts once
    id3_seen = 0;
    n_xfer = 0;
    got3 = 1'b0;
    req_valid = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      randomize_payload();
      step();
      if (!got3 && samp_rdy != 4'b0000) n_xfer++;
      if (samp_rdy[3]) begin
        got3 = 1'b1;
        req_valid[3] = 1'b0;
      end
    end
    check("fair_granted", 32'(got3), 32'(1));
    check("fair_bound", 32'(n_xfer <= 4), 32'(1));
    check("fair_once", 32'(id3_seen), 32'(1));

    // Reset asserted mid-run with a response pending
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    step();
    req_valid = 4'b1111;
    drive();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(rsp_valid), 32'(0));
    check("midrst_data", 32'(rsp_data), 32'(0));
    check("midrst_ready", 32'(req_ready), 32'(0));
    sbq.delete();
    m_valid = 1'b0;
    m_ptr = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    step();
    check("post_rst_grant", 32'(samp_rdy), 32'(4'b0001));
    req_valid = 4'b0000;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
